// File: rtl/conway_pkg.sv
// Shared definitions for the Conway neighbour-window block.
// Holds the FSM state enum and the bit positions of each neighbour in the
// 8-bit neighbour vector. Optional feature macro: CONWAY_WINDOW_LIVECOUNT_EN.
package conway_pkg;

  typedef enum logic [0:0] {
    LOAD = 1'b0,
    SCAN = 1'b1
  } state_e;

  localparam int unsigned NB_NW = 0;
  localparam int unsigned NB_N  = 1;
  localparam int unsigned NB_NE = 2;
  localparam int unsigned NB_W  = 3;
  localparam int unsigned NB_E  = 4;
  localparam int unsigned NB_SW = 5;
  localparam int unsigned NB_S  = 6;
  localparam int unsigned NB_SE = 7;
  localparam int unsigned NB_COUNT = 8;

endpackage

// File: rtl/conway_board_regs.sv
// W x H single-bit board storage with a zero-padded 3x3 window read.
// Ports: clk, rst (async active-low, clears board); wr_en/wr_row/wr_col/wr_bit
// write one cell; rd_row/rd_col select a centre, rd_centre_c/rd_neighbors_c
// return that cell and its 8 neighbours combinationally (off-board reads 0).
module conway_board_regs
  import conway_pkg::*;
#(
  parameter int unsigned W = 8,
  parameter int unsigned H = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [$clog2(H)-1:0]  wr_row,
  input  logic [$clog2(W)-1:0]  wr_col,
  input  logic                  wr_bit,
  input  logic [$clog2(H)-1:0]  rd_row,
  input  logic [$clog2(W)-1:0]  rd_col,
  output logic                  rd_centre_c,
  output logic [NB_COUNT-1:0]   rd_neighbors_c
);

  localparam int unsigned PRW = $clog2(H + 2);
  localparam int unsigned PCW = $clog2(W + 2);

  logic [H-1:0][W-1:0]     board_q;
  logic [H-1:0][W-1:0]     board_d;
  logic [H+1:0][W+1:0]     pad_c;
  logic [PRW-1:0]          pr0, pr1, pr2;
  logic [PCW-1:0]          pc0, pc1, pc2;

  // Single-cell write.
  always_comb begin
    board_d = board_q;
    if (wr_en) board_d[wr_row][wr_col] = wr_bit;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) board_q <= '0;
    else      board_q <= board_d;
  end

  // Board surrounded by a ring of dead cells so edge windows need no special case.
  always_comb begin
    pad_c = '0;
    for (int r = 0; r < int'(H); r++) begin
      for (int c = 0; c < int'(W); c++) begin
        pad_c[r+1][c+1] = board_q[r][c];
      end
    end
  end

  // Padded row/col index of centre is (rd+1); window spans rd..rd+2.
  always_comb begin
    pr0 = PRW'(rd_row);
    pr1 = pr0 + PRW'(1);
    pr2 = pr0 + PRW'(2);
    pc0 = PCW'(rd_col);
    pc1 = pc0 + PCW'(1);
    pc2 = pc0 + PCW'(2);
    rd_centre_c           = pad_c[pr1][pc1];
    rd_neighbors_c        = '0;
    rd_neighbors_c[NB_NW] = pad_c[pr0][pc0];
    rd_neighbors_c[NB_N]  = pad_c[pr0][pc1];
    rd_neighbors_c[NB_NE] = pad_c[pr0][pc2];
    rd_neighbors_c[NB_W]  = pad_c[pr1][pc0];
    rd_neighbors_c[NB_E]  = pad_c[pr1][pc2];
    rd_neighbors_c[NB_SW] = pad_c[pr2][pc0];
    rd_neighbors_c[NB_S]  = pad_c[pr2][pc1];
    rd_neighbors_c[NB_SE] = pad_c[pr2][pc2];
  end

endmodule

// File: rtl/conway_neighbor_window.sv
// Loads a W x H Life board in raster order, then streams one 3x3 window per
// cell (centre + 8 neighbours, off-board = dead) with valid/ready handshake.
// Ports: clk, rst (async active-low); in_valid/in_ready/in_cell load stream;
// out_valid/out_ready, out_state_0, out_neighbors, out_row, out_col, out_last
// window stream. With macro CONWAY_WINDOW_LIVECOUNT_EN an extra live_count
// output reports the live cells of the last fully loaded board.
module conway_neighbor_window
  import conway_pkg::*;
#(
  parameter int unsigned W = 8,
  parameter int unsigned H = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_cell,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_state_0,
  output logic [7:0]              out_neighbors,
  output logic [$clog2(H)-1:0]    out_row,
  output logic [$clog2(W)-1:0]    out_col,
  output logic                    out_last
`ifdef CONWAY_WINDOW_LIVECOUNT_EN
  ,
  output logic [$clog2(W*H+1)-1:0] live_count
`endif
);

  localparam int unsigned RW  = $clog2(H);
  localparam int unsigned CW  = $clog2(W);
  localparam logic [RW-1:0] ROW_LAST = RW'(H - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(W - 1);

  state_e        state_q, state_d;
  logic [RW-1:0] load_row_q, load_row_d;
  logic [CW-1:0] load_col_q, load_col_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic          state0_q, state0_d;
  logic [7:0]    nb_q, nb_d;
  logic          last_q, last_d;

  logic          wr_en_c;
  logic [RW-1:0] nxt_row_c, rd_row_c;
  logic [CW-1:0] nxt_col_c, rd_col_c;
  logic          win_centre_c;
  logic [7:0]    win_nb_c;

`ifdef CONWAY_WINDOW_LIVECOUNT_EN
  localparam int unsigned LCW = $clog2(W*H + 1);
  logic [LCW-1:0] live_acc_q, live_acc_d;
  logic [LCW-1:0] live_q, live_d;
`endif

  conway_board_regs #(.W(W), .H(H)) u_board (
    .clk            (clk),
    .rst            (rst),
    .wr_en          (wr_en_c),
    .wr_row         (load_row_q),
    .wr_col         (load_col_q),
    .wr_bit         (in_cell),
    .rd_row         (rd_row_c),
    .rd_col         (rd_col_c),
    .rd_centre_c    (win_centre_c),
    .rd_neighbors_c (win_nb_c)
  );

  // Read address is the centre presented after the next edge: (0,0) when
  // entering SCAN, the following raster position while scanning.
  always_comb begin
    nxt_row_c = row_q;
    nxt_col_c = col_q + CW'(1);
    if (col_q == COL_LAST) begin
      nxt_col_c = '0;
      nxt_row_c = row_q + RW'(1);
    end
    rd_row_c = (state_q == SCAN) ? nxt_row_c : '0;
    rd_col_c = (state_q == SCAN) ? nxt_col_c : '0;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    load_row_d = load_row_q;
    load_col_d = load_col_q;
    row_d      = row_q;
    col_d      = col_q;
    state0_d   = state0_q;
    nb_d       = nb_q;
    last_d     = last_q;
    wr_en_c    = 1'b0;
`ifdef CONWAY_WINDOW_LIVECOUNT_EN
    live_acc_d = live_acc_q;
    live_d     = live_q;
`endif
    unique case (state_q)
      LOAD: begin
        if (in_valid) begin
          wr_en_c    = 1'b1;
          load_col_d = load_col_q + CW'(1);
`ifdef CONWAY_WINDOW_LIVECOUNT_EN
          live_acc_d = live_acc_q + LCW'(in_cell);
`endif
          if (load_col_q == COL_LAST) begin
            load_col_d = '0;
            load_row_d = load_row_q + RW'(1);
            if (load_row_q == ROW_LAST) begin
              // Final cell never lies inside the (0,0) window since W,H >= 3.
              load_row_d = '0;
              state_d    = SCAN;
              row_d      = '0;
              col_d      = '0;
              state0_d   = win_centre_c;
              nb_d       = win_nb_c;
              last_d     = 1'b0;
`ifdef CONWAY_WINDOW_LIVECOUNT_EN
              live_d     = live_acc_q + LCW'(in_cell);
              live_acc_d = '0;
`endif
            end
          end
        end
      end
      SCAN: begin
        if (out_ready) begin
          if (last_q) begin
            state_d  = LOAD;
            row_d    = '0;
            col_d    = '0;
            state0_d = 1'b0;
            nb_d     = '0;
            last_d   = 1'b0;
          end else begin
            row_d    = nxt_row_c;
            col_d    = nxt_col_c;
            state0_d = win_centre_c;
            nb_d     = win_nb_c;
            last_d   = (nxt_row_c == ROW_LAST) && (nxt_col_c == COL_LAST);
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= LOAD;
      load_row_q <= '0;
      load_col_q <= '0;
      row_q      <= '0;
      col_q      <= '0;
      state0_q   <= 1'b0;
      nb_q       <= '0;
      last_q     <= 1'b0;
`ifdef CONWAY_WINDOW_LIVECOUNT_EN
      live_acc_q <= '0;
      live_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      load_row_q <= load_row_d;
      load_col_q <= load_col_d;
      row_q      <= row_d;
      col_q      <= col_d;
      state0_q   <= state0_d;
      nb_q       <= nb_d;
      last_q     <= last_d;
`ifdef CONWAY_WINDOW_LIVECOUNT_EN
      live_acc_q <= live_acc_d;
      live_q     <= live_d;
`endif
    end
  end

  assign in_ready      = (state_q == LOAD);
  assign out_valid     = (state_q == SCAN);
  assign out_state_0   = state0_q;
  assign out_neighbors = nb_q;
  assign out_row       = row_q;
  assign out_col       = col_q;
  assign out_last      = last_q;
`ifdef CONWAY_WINDOW_LIVECOUNT_EN
  assign live_count    = live_q;
`endif

endmodule

// File: tb/tb_conway_neighbor_window.sv
// Randomised self-checking bench for conway_neighbor_window (8x8 board).
module tb_conway_neighbor_window;

  localparam int W = 8;
  localparam int H = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       in_cell = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       out_state_0;
  logic [7:0] out_neighbors;
  logic [2:0] out_row;
  logic [2:0] out_col;
  logic       out_last;
`ifdef CONWAY_WINDOW_LIVECOUNT_EN
  logic [6:0] live_count;
`endif

  int         n_checks = 0;
  int         n_pass = 0;
  int         mdl[H][W];
  int         mdl_live = 0;
  logic [7:0] obs_nb[H][W];
  logic       obs_c[H][W];
  int         cyc_cnt;

  conway_neighbor_window #(.W(W), .H(H)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_cell       (in_cell),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_state_0   (out_state_0),
    .out_neighbors (out_neighbors),
    .out_row       (out_row),
    .out_col       (out_col),
    .out_last      (out_last)
`ifdef CONWAY_WINDOW_LIVECOUNT_EN
    ,
    .live_count    (live_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Model: cell value with everything off the board dead.
  function automatic int cell_at(input int r, input int c);
    if (r < 0 || r >= H || c < 0 || c >= W) return 0;
    return mdl[r][c];
  endfunction

  // Neighbour order NW,N,NE,W,E,SW,S,SE as (row, col) offsets.
  function automatic logic [7:0] model_nb(input int r, input int c);
    int dr[8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
    int dc[8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
    logic [7:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v[i] = (cell_at(r + dr[i], c + dc[i]) != 0);
    return v;
  endfunction

  // kind: 0 zeros, 1 single live (3,3), 2 all ones, other random; n cells sent.
  task automatic load_cells(input int kind, input int n);
    int pat[H*W];
    int k;
    int guard;
    int ones;
    ones = 0;
    for (int i = 0; i < H*W; i++) begin
      case (kind)
        0:       pat[i] = 0;
        1:       pat[i] = (i == 3*W + 3) ? 1 : 0;
        2:       pat[i] = 1;
        default: pat[i] = int'($urandom_range(1));
      endcase
      ones += pat[i];
    end
    k = 0;
    guard = 0;
    while (k < n && guard < 4*H*W) begin
      @(negedge clk);
      guard++;
      check_eq("load_in_ready", 32'(in_ready), 32'd1);
      check_eq("load_out_valid", 32'(out_valid), 32'd0);
`ifdef CONWAY_WINDOW_LIVECOUNT_EN
      check_eq("load_live_hold", 32'(live_count), 32'(mdl_live));
`endif
      in_valid  = ($urandom_range(3) != 0);
      in_cell   = in_valid ? 1'(pat[k]) : 1'($urandom_range(1));
      out_ready = 1'($urandom_range(1));
      @(posedge clk);
      if (in_valid) k++;
    end
    check_eq("load_count", 32'(k), 32'(n));
    if (n == H*W) begin
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++) mdl[r][c] = pat[r*W + c];
      mdl_live = ones;
    end
  endtask

  // mode 0: ready always 1; 1: random ready; 2: ready 1,0,0,1 then 1.
  task automatic scan_frame(input int mode, output int cycles);
    int   r, c, cyc;
    logic done;
    logic was_last;
    r = 0; c = 0; cyc = 0; done = 1'b0;
    while (!done && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      check_eq("scan_out_valid", 32'(out_valid), 32'd1);
      check_eq("scan_in_ready", 32'(in_ready), 32'd0);
      check_eq("scan_row", 32'(out_row), 32'(r));
      check_eq("scan_col", 32'(out_col), 32'(c));
      check_eq("scan_state0", 32'(out_state_0), 32'(cell_at(r, c)));
      check_eq("scan_nb", 32'(out_neighbors), 32'(model_nb(r, c)));
      check_eq("scan_last", 32'(out_last), 32'((r == H-1 && c == W-1) ? 1 : 0));
`ifdef CONWAY_WINDOW_LIVECOUNT_EN
      check_eq("scan_live", 32'(live_count), 32'(mdl_live));
`endif
      obs_nb[r][c] = out_neighbors;
      obs_c[r][c]  = out_state_0;
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(1));
        default: out_ready = (cyc == 2 || cyc == 3) ? 1'b0 : 1'b1;
      endcase
      in_valid = 1'($urandom_range(1));
      in_cell  = 1'($urandom_range(1));
      was_last = (r == H-1 && c == W-1);
      @(posedge clk);
      if (out_ready) begin
        if (was_last) done = 1'b1;
        else if (c == W-1) begin c = 0; r++; end
        else c++;
      end
    end
    cycles = cyc;
    check_eq("scan_done", 32'(done), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("post_in_ready", 32'(in_ready), 32'd1);
    check_eq("post_out_valid", 32'(out_valid), 32'd0);
    check_eq("post_row", 32'(out_row), 32'd0);
    check_eq("post_col", 32'(out_col), 32'd0);
    check_eq("post_last", 32'(out_last), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check_eq({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check_eq({tag, "_state0"}, 32'(out_state_0), 32'd0);
    check_eq({tag, "_nb"}, 32'(out_neighbors), 32'd0);
    check_eq({tag, "_row"}, 32'(out_row), 32'd0);
    check_eq({tag, "_col"}, 32'(out_col), 32'd0);
    check_eq({tag, "_last"}, 32'(out_last), 32'd0);
`ifdef CONWAY_WINDOW_LIVECOUNT_EN
    check_eq({tag, "_live"}, 32'(live_count), 32'd0);
`endif
  endtask

  initial begin
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) mdl[r][c] = 0;

    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;

    // All-zero board, ready held high: exactly W*H scan cycles.
    load_cells(0, H*W);
    scan_frame(0, cyc_cnt);
    check_eq("zero_scan_cycles", 32'(cyc_cnt), 32'(H*W));

    // Single live cell at (3,3).
    load_cells(1, H*W);
    scan_frame(1, cyc_cnt);
    check_eq("single_nb_2_2", 32'(obs_nb[2][2]), 32'h80);
    check_eq("single_nb_3_4", 32'(obs_nb[3][4]), 32'h08);
    check_eq("single_c_3_3", 32'(obs_c[3][3]), 32'd1);
    check_eq("single_nb_3_3", 32'(obs_nb[3][3]), 32'h00);

    // All-ones board with back-pressure pattern 1,0,0,1.
    load_cells(2, H*W);
    scan_frame(2, cyc_cnt);
    check_eq("ones_scan_cycles", 32'(cyc_cnt), 32'(H*W + 2));
    check_eq("ones_nb_0_0", 32'(obs_nb[0][0]), 32'hD0);
    check_eq("ones_nb_0_3", 32'(obs_nb[0][3]), 32'hF8);
    check_eq("ones_nb_4_4", 32'(obs_nb[4][4]), 32'hFF);

    // Reset after 20 loaded cells, then a fresh all-ones frame.
    load_cells(3, 20);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    mdl_live = 0;
    #1;
    check_reset_outputs("midload_rst");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    load_cells(2, H*W);
`ifdef CONWAY_WINDOW_LIVECOUNT_EN
    @(negedge clk);
    check_eq("live_all_ones", 32'(live_count), 32'd64);
`endif
    scan_frame(1, cyc_cnt);

    // Reset in the middle of a scan; next frame must start from (0,0).
    load_cells(3, H*W);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    mdl_live = 0;
    #1;
    check_reset_outputs("midscan_rst");
    @(negedge clk);
    rst = 1'b1;

    // Random frames with random back-pressure.
    for (int f = 0; f < 3; f++) begin
      load_cells(3, H*W);
      scan_frame(1, cyc_cnt);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/conway_neighbor_window.md
CONWAY_NEIGHBOR_WINDOW -- requirements
Module: conway_neighbor_window

Interface
REQ-001 SHALL have parameter W, default 8, meaning board width in cells (W >= 3).
REQ-002 SHALL have parameter H, default 8, meaning board height in cells (H >= 3).
REQ-003 SHALL have ports: clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have ports: rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports: in_valid  input  1  in_cell is valid; in_ready  output  1  block accepts a cell; in_cell  input  1  cell state, raster order (row 0 col 0 first).
REQ-006 SHALL have ports: out_valid  output  1  window valid; out_ready  input  1  consumer accepts window.
REQ-007 SHALL have ports: out_state_0  output  1  centre cell state; out_neighbors  output  8  neighbour states.
REQ-008 SHALL have ports: out_row  output  $clog2(H)  centre row; out_col  output  $clog2(W)  centre column; out_last  output  1  final window of the frame.

Function
REQ-009 SHALL hold a W x H bit board and run a two-state FSM: LOAD, SCAN.
REQ-010 In LOAD, in_ready SHALL be 1 and out_valid 0; each cycle with in_valid & in_ready SHALL write in_cell to the board at (load_row, load_col), then advance column-major-inner raster order (col increments, wraps to 0 at W-1 with row increment).
REQ-011 The transfer of cell (H-1, W-1) SHALL move the FSM to SCAN on the next edge, with load counters returned to 0.
REQ-012 In SCAN, in_ready SHALL be 0 and out_valid 1. Windows SHALL be presented in raster order from (0,0). Each out_valid & out_ready transfer SHALL advance to the next centre.
REQ-013 out_state_0 SHALL equal board[row][col]. out_neighbors bit mapping SHALL be 0=NW, 1=N, 2=NE, 3=W, 4=E, 5=SW, 6=S, 7=SE.
REQ-014 Neighbours outside the board SHALL read as 0 (dead); no wrap-around.
REQ-015 While out_valid=1 and out_ready=0, all out_* signals SHALL be held stable.
REQ-016 out_last SHALL be 1 only for centre (H-1, W-1). Its transfer SHALL return the FSM to LOAD on the next edge, with scan counters at 0.
REQ-017 First window SHALL be valid on the cycle after the final load transfer; with out_ready held 1, SCAN SHALL last exactly W*H cycles.
REQ-018 Board contents SHALL persist through SCAN and be overwritten only by the next LOAD.
REQ-019 in_valid in SCAN and out_ready in LOAD SHALL be ignored.

Reset
REQ-020 While rst=0, the block SHALL be in LOAD with the board cleared to all 0 and all counters 0.
REQ-021 Reset outputs: in_ready=1, out_valid=0, out_state_0=0, out_neighbors=0, out_row=0, out_col=0, out_last=0.
REQ-022 Assertion of rst mid-LOAD or mid-SCAN SHALL abandon the frame immediately; no partial window SHALL be emitted afterwards.

Configuration
REQ-023 When macro CONWAY_WINDOW_LIVECOUNT_EN is defined, the block SHALL add port live_count  output  $clog2(W*H+1)  number of live cells in the last fully loaded board.
REQ-024 With the macro, live_count SHALL be 0 at reset and SHALL update on the edge that enters SCAN. It SHALL hold through SCAN and the next LOAD.
REQ-025 Without the macro, the port and counter SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-026 Shared package conway_pkg SHALL hold the FSM state enum (LOAD, SCAN) and the neighbour bit-index localparams (NB_NW..NB_SE).
REQ-027 Board storage with zero-padded 3x3 read SHALL be sub-module conway_board_regs: write port (row, col, bit) and a combinational window read port at (row, col).

Verification
REQ-028 Scenario: load 8x8 all-zero board, out_ready=1 -> 64 windows, all outputs 0, out_last only on (7,7), then in_ready=1.
REQ-029 Scenario: single live cell at (3,3) -> window (2,2) neighbors=8'b1000_0000, (3,4) neighbors=8'b0000_1000, (3,3) state_0=1 neighbors=0.
REQ-030 Scenario: all-ones board -> corner (0,0) neighbors=8'b1101_0000, edge (0,3) neighbors=8'b1111_1000, interior (4,4) neighbors=8'hFF.
REQ-031 Scenario: out_ready toggled 1,0,0,1 during SCAN -> window (0,1) held stable for 3 cycles; no window skipped or duplicated.
REQ-032 Scenario: rst pulsed low after 20 loaded cells, then a full new frame loaded -> outputs reflect only the new frame; with CONWAY_WINDOW_LIVECOUNT_EN, all-ones frame gives live_count=64.
REQ-033 Scenario: in_valid held 1 during SCAN and with gaps during LOAD -> SCAN data unaffected; load order preserved across gaps.
